// File: rtl/gb_pkg.sv
// rtl/gb_pkg.sv - shared encodings for the memory bus sequencer and instruction decoder
package gb_pkg;

  localparam logic [1:0] T1 = 2'b00;
  localparam logic [1:0] T2 = 2'b01;
  localparam logic [1:0] T3 = 2'b10;
  localparam logic [1:0] T4 = 2'b11;

  localparam logic [7:0] OPEN_BUS_DFLT = 8'hFF;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_FETCH,
    BUS_RD,
    BUS_WR
  } bus_op_e;

  typedef enum logic [2:0] {
    IDLE,
    T1_ADDR,
    T2_STRB,
    T3_SAMP,
    T3_WAIT,
    T4_DONE
  } bus_state_e;

  typedef enum logic [2:0] {
    REG_B  = 3'd0,
    REG_C  = 3'd1,
    REG_D  = 3'd2,
    REG_E  = 3'd3,
    REG_H  = 3'd4,
    REG_L  = 3'd5,
    MEM_HL = 3'd6,
    REG_A  = 3'd7
  } reg_sel_e;

  typedef enum logic [1:0] {
    DBUS_SBUS,
    DBUS_ALU,
    DBUS_MEM,
    DBUS_DEBUG
  } dbus_sel_e;

endpackage

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - 16-bit program counter; load beats increment, increment wraps
module pc_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        inc,
  output logic [15:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + 16'd1;
    end
  end

endmodule

// File: rtl/bus_ctrl.sv
// rtl/bus_ctrl.sv - M-cycle sequencer: opcode fetch, data read/write, wait states, mdr
module bus_ctrl
  import gb_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned WAIT_MAX = 8,
  parameter logic [7:0]  OPEN_BUS = OPEN_BUS_DFLT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  t_cycle,
  input  logic        fetch_req,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [15:0] data_addr,
  input  logic [7:0]  data_wdata,
  input  logic        pc_load,
  input  logic [15:0] pc_load_val,
  input  logic        pc_inc,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic [7:0]  mdr,
  output logic        mdr_valid,
  output logic [15:0] pc,
  output logic        hold_req,
  output logic        timeout,
  output logic        proto_err
);

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  bus_state_e  state, state_n;
  bus_op_e     op, op_n;
  logic [15:0] addr_n;
  logic [7:0]  wdata_n, mdr_n, wait_cnt, wait_cnt_n;
  logic        rd_n, wr_n, mdr_valid_n, hold_n, timeout_n, proto_n;
  logic        acc_done, acc_abort, fetch_inc;

  always_comb begin
    state_n     = state;
    op_n        = op;
    addr_n      = mem_addr;
    wdata_n     = mem_wdata;
    rd_n        = mem_rd;
    wr_n        = mem_wr;
    mdr_n       = mdr;
    mdr_valid_n = 1'b0;
    hold_n      = hold_req;
    timeout_n   = timeout;
    proto_n     = proto_err;
    wait_cnt_n  = wait_cnt;
    acc_done    = 1'b0;
    acc_abort   = 1'b0;
    fetch_inc   = 1'b0;

    case (state)
      // T4 also accepts a new request so back-to-back M-cycles lose no clock
      IDLE, T4_DONE: begin
        state_n = IDLE;
        op_n    = BUS_IDLE;
        if (t_cycle == T1 && (fetch_req || data_req)) begin
          state_n    = T1_ADDR;
          wait_cnt_n = 8'd0;
          proto_n    = proto_err | (fetch_req & data_req);
          if (data_req) begin
            op_n   = data_we ? BUS_WR : BUS_RD;
            addr_n = data_addr;
          end else begin
            op_n   = BUS_FETCH;
            addr_n = pc;
          end
        end
      end
      T1_ADDR: begin
        state_n = T2_STRB;
        if (op == BUS_WR) wdata_n = data_wdata;
        else              rd_n    = 1'b1;
      end
      T2_STRB: begin
        state_n = T3_SAMP;
        if (op == BUS_WR) wr_n = 1'b1;
      end
      T3_SAMP: begin
        if (mem_ready) begin
          acc_done = 1'b1;
        end else begin
          state_n    = T3_WAIT;
          hold_n     = 1'b1;
          wait_cnt_n = 8'd1;
        end
      end
      T3_WAIT: begin
        if (mem_ready)                 acc_done   = 1'b1;
        else if (wait_cnt >= WAIT_LIM) acc_abort  = 1'b1;
        else                           wait_cnt_n = wait_cnt + 8'd1;
      end
      default: state_n = IDLE;
    endcase

    if (acc_done || acc_abort) begin
      state_n   = T4_DONE;
      rd_n      = 1'b0;
      wr_n      = 1'b0;
      hold_n    = 1'b0;
      timeout_n = timeout | acc_abort;
      fetch_inc = (op == BUS_FETCH);
      if (op != BUS_WR) begin
        mdr_n       = acc_abort ? OPEN_BUS : mem_rdata;
        mdr_valid_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op        <= BUS_IDLE;
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mdr       <= 8'h00;
      mdr_valid <= 1'b0;
      hold_req  <= 1'b0;
      timeout   <= 1'b0;
      proto_err <= 1'b0;
      wait_cnt  <= 8'd0;
    end else begin
      state     <= state_n;
      op        <= op_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      mem_rd    <= rd_n;
      mem_wr    <= wr_n;
      mdr       <= mdr_n;
      mdr_valid <= mdr_valid_n;
      hold_req  <= hold_n;
      timeout   <= timeout_n;
      proto_err <= proto_n;
      wait_cnt  <= wait_cnt_n;
    end
  end

  // Fetch increment lands on entry to T4 so a back-to-back fetch addresses the next byte
  pc_unit #(.RESET_PC(RESET_PC)) u_pc (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .load_val (pc_load_val),
    .inc      (fetch_inc | pc_inc),
    .pc       (pc)
  );

endmodule

// File: tb/tb_bus_ctrl.sv
// tb/tb_bus_ctrl.sv - self-checking bench for bus_ctrl with an mdr scoreboard
module tb_bus_ctrl;
  import gb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  t_cycle;
  logic        fetch_req, data_req, data_we, pc_load, pc_inc, mem_ready;
  logic [15:0] data_addr, pc_load_val, mem_addr, pc;
  logic [7:0]  data_wdata, mem_wdata, mem_rdata, mdr;
  logic        mem_rd, mem_wr, mdr_valid, hold_req, timeout, proto_err;

  int n_checks = 0;
  int n_fails  = 0;
  logic [7:0] sb[$];
  logic [7:0] sb_exp;

  always #5 clk = ~clk;

  bus_ctrl #(.RESET_PC(16'h0100), .WAIT_MAX(8), .OPEN_BUS(8'hFF)) dut (
    .clk(clk), .rst(rst), .t_cycle(t_cycle), .fetch_req(fetch_req), .data_req(data_req),
    .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .pc_inc(pc_inc), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mdr(mdr), .mdr_valid(mdr_valid), .pc(pc), .hold_req(hold_req), .timeout(timeout),
    .proto_err(proto_err)
  );

  // Every mdr_valid pulse must match the oldest expected read value
  always @(negedge clk) begin
    if (mdr_valid) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fails++; $display("FAIL mdr_sb unexpected mdr_valid, mdr %h, want no pulse", mdr);
      end else begin
        sb_exp = sb.pop_front();
        if (mdr !== sb_exp) begin n_fails++; $display("FAIL mdr_sb got %h want %h", mdr, sb_exp); end
      end
    end
  end

  task automatic start_req(input logic f, input logic d, input logic we,
                           input logic [15:0] a, input logic [7:0] wd);
    t_cycle = T1; fetch_req = f; data_req = d; data_we = we; data_addr = a; data_wdata = wd;
    @(negedge clk);
    t_cycle = T2; fetch_req = 1'b0; data_req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (pc !== 16'h0100) begin n_fails++; $display("FAIL reset_pc got %h want 0100", pc); end
    n_checks++; if ({mem_rd, mem_wr, mdr_valid, hold_req, timeout, proto_err} !== 6'b0) begin
      n_fails++; $display("FAIL reset_flags got %b want 000000", {mem_rd, mem_wr, mdr_valid, hold_req, timeout, proto_err}); end
    n_checks++; if ({mem_addr, mem_wdata, mdr} !== 32'h0) begin
      n_fails++; $display("FAIL reset_regs got %h want 0", {mem_addr, mem_wdata, mdr}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fetch;
    mem_rdata = 8'h3E; sb.push_back(8'h3E);
    start_req(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    n_checks++; if (mem_addr !== 16'h0100 || mem_rd !== 1'b0) begin
      n_fails++; $display("FAIL fetch_t1 got addr %h rd %b want 0100 0", mem_addr, mem_rd); end
    @(negedge clk);
    n_checks++; if (mem_rd !== 1'b1) begin n_fails++; $display("FAIL fetch_t2_rd got %b want 1", mem_rd); end
    @(negedge clk);
    n_checks++; if (mem_rd !== 1'b1 || mdr_valid !== 1'b0) begin
      n_fails++; $display("FAIL fetch_t3 got rd %b valid %b want 1 0", mem_rd, mdr_valid); end
    @(negedge clk);
    n_checks++; if (mem_rd !== 1'b0 || mdr_valid !== 1'b1 || pc !== 16'h0101 || mem_addr !== 16'h0100) begin
      n_fails++; $display("FAIL fetch_t4 got rd %b valid %b pc %h addr %h want 0 1 0101 0100", mem_rd, mdr_valid, pc, mem_addr); end
    @(negedge clk);
  endtask

  task automatic test_ignore_outside_t1;
    t_cycle = T3; fetch_req = 1'b1; data_req = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (mem_rd !== 1'b0 || pc !== 16'h0101 || proto_err !== 1'b0) begin
      n_fails++; $display("FAIL ignore_req got rd %b pc %h perr %b want 0 0101 0", mem_rd, pc, proto_err); end
    fetch_req = 1'b0; data_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write;
    start_req(1'b0, 1'b1, 1'b1, 16'hC000, 8'h5A);
    n_checks++; if (mem_addr !== 16'hC000 || mem_wr !== 1'b0) begin
      n_fails++; $display("FAIL write_t1 got addr %h wr %b want c000 0", mem_addr, mem_wr); end
    @(negedge clk);
    n_checks++; if (mem_wr !== 1'b0 || mem_rd !== 1'b0 || mem_wdata !== 8'h5A) begin
      n_fails++; $display("FAIL write_t2 got wr %b rd %b wdata %h want 0 0 5a", mem_wr, mem_rd, mem_wdata); end
    @(negedge clk);
    n_checks++; if (mem_wr !== 1'b1) begin n_fails++; $display("FAIL write_t3_wr got %b want 1", mem_wr); end
    @(negedge clk);
    n_checks++; if (mem_wr !== 1'b0 || mdr_valid !== 1'b0 || mdr !== 8'h3E || pc !== 16'h0101) begin
      n_fails++; $display("FAIL write_t4 got wr %b valid %b mdr %h pc %h want 0 0 3e 0101", mem_wr, mdr_valid, mdr, pc); end
    @(negedge clk);
  endtask

  task automatic test_wait_states;
    int lat = 0;
    int hc = 0;
    mem_rdata = 8'hC3; mem_ready = 1'b0; sb.push_back(8'hC3);
    start_req(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    for (int k = 2; k <= 30; k++) begin
      @(negedge clk);
      if (hold_req) hc++;
      if (mdr_valid && lat == 0) lat = k - 1;
      if (k == 6) mem_ready = 1'b1;
      if (lat != 0) break;
    end
    n_checks++; if (lat != 6) begin n_fails++; $display("FAIL wait_latency got %0d want 6", lat); end
    n_checks++; if (hc != 3) begin n_fails++; $display("FAIL wait_hold_clks got %0d want 3", hc); end
    n_checks++; if (pc !== 16'h0102 || hold_req !== 1'b0) begin
      n_fails++; $display("FAIL wait_end got pc %h hold %b want 0102 0", pc, hold_req); end
    mem_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int lat = 0;
    int hc = 0;
    logic [1:0] strb = 2'b11;
    n_checks++; if (timeout !== 1'b0) begin n_fails++; $display("FAIL timeout_pre got %b want 0", timeout); end
    mem_ready = 1'b0; sb.push_back(8'hFF);
    start_req(1'b0, 1'b1, 1'b0, 16'h8000, 8'h0);
    for (int k = 2; k <= 40; k++) begin
      @(negedge clk);
      if (hold_req) hc++;
      if (mdr_valid && lat == 0) begin lat = k - 1; strb = {mem_rd, mem_wr}; end
      if (lat != 0) break;
    end
    n_checks++; if (lat != 11) begin n_fails++; $display("FAIL abort_latency got %0d want 11", lat); end
    n_checks++; if (hc != 8) begin n_fails++; $display("FAIL abort_hold_clks got %0d want 8", hc); end
    n_checks++; if (timeout !== 1'b1 || strb !== 2'b00) begin
      n_fails++; $display("FAIL abort_state got timeout %b strobes %b want 1 00", timeout, strb); end
    mem_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_protocol;
    n_checks++; if (proto_err !== 1'b0) begin n_fails++; $display("FAIL proto_pre got %b want 0", proto_err); end
    mem_rdata = 8'h77; sb.push_back(8'h77);
    start_req(1'b1, 1'b1, 1'b0, 16'h1234, 8'h0);
    n_checks++; if (mem_addr !== 16'h1234 || proto_err !== 1'b1) begin
      n_fails++; $display("FAIL proto_both got addr %h perr %b want 1234 1", mem_addr, proto_err); end
    repeat (3) @(negedge clk);
    n_checks++; if (mdr_valid !== 1'b1 || pc !== 16'h0102) begin
      n_fails++; $display("FAIL proto_done got valid %b pc %h want 1 0102", mdr_valid, pc); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    mem_rdata = 8'hA1; sb.push_back(8'hA1);
    start_req(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    repeat (3) @(negedge clk);
    n_checks++; if (mdr_valid !== 1'b1 || pc !== 16'h0103) begin
      n_fails++; $display("FAIL b2b_first got valid %b pc %h want 1 0103", mdr_valid, pc); end
    mem_rdata = 8'hB2; sb.push_back(8'hB2);
    start_req(1'b0, 1'b1, 1'b0, 16'h2000, 8'h0);
    n_checks++; if (mem_addr !== 16'h2000 || mdr_valid !== 1'b0) begin
      n_fails++; $display("FAIL b2b_second_t1 got addr %h valid %b want 2000 0", mem_addr, mdr_valid); end
    repeat (3) @(negedge clk);
    n_checks++; if (mdr_valid !== 1'b1 || pc !== 16'h0103) begin
      n_fails++; $display("FAIL b2b_second got valid %b pc %h want 1 0103", mdr_valid, pc); end
    @(negedge clk);
  endtask

  task automatic test_pc_wrap;
    pc_load = 1'b1; pc_load_val = 16'hFFFF;
    @(negedge clk);
    pc_load = 1'b0;
    n_checks++; if (pc !== 16'hFFFF) begin n_fails++; $display("FAIL pc_load_idle got %h want ffff", pc); end
    mem_rdata = 8'h00; sb.push_back(8'h00);
    start_req(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    repeat (3) @(negedge clk);
    n_checks++; if (pc !== 16'h0000 || mem_addr !== 16'hFFFF) begin
      n_fails++; $display("FAIL pc_wrap got pc %h addr %h want 0000 ffff", pc, mem_addr); end
    @(negedge clk);
    mem_rdata = 8'h11; sb.push_back(8'h11);
    start_req(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    n_checks++; if (mem_addr !== 16'h0000) begin n_fails++; $display("FAIL pc_wrap_addr got %h want 0000", mem_addr); end
    repeat (2) @(negedge clk);
    pc_load = 1'b1; pc_load_val = 16'h0038;
    @(negedge clk);
    pc_load = 1'b0;
    n_checks++; if (pc !== 16'h0038) begin n_fails++; $display("FAIL pc_load_prio got %h want 0038", pc); end
    @(negedge clk);
    mem_rdata = 8'h22; sb.push_back(8'h22);
    start_req(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    repeat (2) @(negedge clk);
    pc_inc = 1'b1;
    @(negedge clk);
    pc_inc = 1'b0;
    n_checks++; if (pc !== 16'h0039) begin n_fails++; $display("FAIL pc_inc_merge got %h want 0039", pc); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write;
    mem_ready = 1'b0;
    start_req(1'b0, 1'b1, 1'b1, 16'hC000, 8'h99);
    repeat (2) @(negedge clk);
    n_checks++; if (mem_wr !== 1'b1) begin n_fails++; $display("FAIL rstw_pre got wr %b want 1", mem_wr); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (mem_wr !== 1'b0 || pc !== 16'h0100 || timeout !== 1'b0 || proto_err !== 1'b0) begin
      n_fails++; $display("FAIL rstw_async got wr %b pc %h to %b perr %b want 0 0100 0 0", mem_wr, pc, timeout, proto_err); end
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    mem_rdata = 8'h5C; sb.push_back(8'h5C);
    start_req(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    n_checks++; if (mem_addr !== 16'h0100) begin n_fails++; $display("FAIL rstw_fetch_addr got %h want 0100", mem_addr); end
    repeat (3) @(negedge clk);
    n_checks++; if (mdr_valid !== 1'b1 || pc !== 16'h0101) begin
      n_fails++; $display("FAIL rstw_fetch got valid %b pc %h want 1 0101", mdr_valid, pc); end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; t_cycle = T2; fetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
    data_addr = 16'h0; data_wdata = 8'h0; pc_load = 1'b0; pc_load_val = 16'h0; pc_inc = 1'b0;
    mem_rdata = 8'h0; mem_ready = 1'b1;
    test_reset();
    test_fetch();
    test_ignore_outside_t1();
    test_write();
    test_wait_states();
    test_timeout();
    test_protocol();
    test_back_to_back();
    test_pc_wrap();
    test_reset_mid_write();
    n_checks++; if (sb.size() != 0) begin n_fails++; $display("FAIL sb_drain got %0d pending want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/bus_ctrl.md
Name: bus_ctrl

Overview:
- Memory bus sequencer directly upstream of the instruction decoder.
- Owns the program counter and runs each 4-T-cycle M-cycle on the external memory bus: opcode fetch, operand/data read, or data write.
- Latches read data into a memory data register (mdr) that feeds the decoder's data_bus_in.
- Supports memory wait states by raising hold_req so the decoder freezes its cycle counter.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
WAIT_MAX, 8, max consecutive wait-state clocks before abort (1..255)
OPEN_BUS, 8'hFF, mdr value returned on an aborted read

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
t_cycle  in  2  current T-cycle from decoder (00=T1..11=T4)
fetch_req  in  1  next M-cycle is an opcode fetch, sampled at T1
data_req  in  1  current M-cycle is a data access, sampled at T1
data_we  in  1  1=write, 0=read; qualifies data_req
data_addr  in  16  data access address (HL, SP, imm, ...)
data_wdata  in  8  write data
pc_load  in  1  load PC with pc_load_val (jump/call/ret)
pc_load_val  in  16  new PC
pc_inc  in  1  advance PC past an immediate operand
mem_addr  out  16  external address bus
mem_wdata  out  8  external write data
mem_rd  out  1  read strobe
mem_wr  out  1  write strobe
mem_rdata  in  8  external read data
mem_ready  in  1  0 = insert wait state
mdr  out  8  memory data register, to decoder data_bus_in
mdr_valid  out  1  one-clock pulse when mdr updated
pc  out  16  program counter
hold_req  out  1  decoder must freeze its cycle counter
timeout  out  1  sticky: a wait-state abort occurred
proto_err  out  1  sticky: fetch_req and data_req both high at T1

Behaviour:
- Reset (async, rst=1): state IDLE, pc=RESET_PC, mdr=8'h00, mem_addr=0, mem_wdata=0, mem_rd=0, mem_wr=0, mdr_valid=0, hold_req=0, timeout=0, proto_err=0. Any in-flight access is dropped immediately.
- FSM states: IDLE, T1_ADDR, T2_STRB, T3_SAMP, T3_WAIT, T4_DONE. Advances one state per clk.
- IDLE -> T1_ADDR when t_cycle==00 and (fetch_req|data_req).
  - Op is latched: data_req wins (RD or WR per data_we), else FETCH.
  - Both requests high sets proto_err.
  - mem_addr = pc for FETCH, data_addr otherwise.
- T1_ADDR -> T2_STRB: mem_rd=1 for FETCH/RD. For WR, mem_wdata=data_wdata is latched.
- T2_STRB -> T3_SAMP: mem_wr=1 for WR.
- T3_SAMP:
  - If mem_ready=1: read ops latch mdr=mem_rdata; go to T4_DONE.
  - Else go to T3_WAIT with hold_req=1 (registered, high from the next clk).
- T3_WAIT: strobes held, hold_req=1, wait counter increments.
  - mem_ready=1: latch mdr (reads), hold_req=0, go to T4_DONE.
  - Counter reaches WAIT_MAX: abort. Reads get mdr=OPEN_BUS; timeout=1; go to T4_DONE.
- T4_DONE: mem_rd=0, mem_wr=0, mdr_valid=1 for reads. FETCH increments pc. Next state is T1_ADDR if a new request is present (back-to-back), else IDLE.
- Latency: request at T1 -> mdr valid at T4 (3 clks) plus wait clocks.
- PC update priority, evaluated each clk: pc_load > (fetch increment | pc_inc).
  - Fetch increment and pc_inc in the same clk advance pc by exactly 1.
  - Increment wraps 16'hFFFF -> 16'h0000.
- mem_addr is held stable from T1 through T4. Strobes never glitch between T1 and T4.
- Requests arriving outside T1 are ignored.
- Write data is not returned on mdr; mdr_valid stays 0 for writes.

Decomposition:
- Shared package gb_pkg holds:
  - T-cycle encodings T1..T4.
  - Bus op enum BUS_IDLE/BUS_FETCH/BUS_RD/BUS_WR.
  - OPEN_BUS default.
  - Register encodings REG_A..MEM_HL.
  - DBUS mux selects SBUS/ALU/MEM/DEBUG.
- One sub-module, pc_unit: 16-bit PC with load/increment priority and wraparound.

Test Plan:
1. Reset with RESET_PC=16'h0100, fetch_req at T1, mem_rdata=8'h3E -> mem_addr=16'h0100, mem_rd high T2-T3, mdr=8'h3E with mdr_valid at T4, pc=16'h0101.
2. data_req, data_we=1, data_addr=16'hC000, data_wdata=8'h5A -> mem_wr high T3 only, mem_wdata=8'h5A, mdr unchanged, pc unchanged.
3. Fetch with mem_ready low 3 clks at T3 -> hold_req high 3 clks, mdr latched on ready, total latency 6 clks.
4. Read with mem_ready stuck low, WAIT_MAX=8 -> abort after 8 wait clks, mdr=8'hFF, timeout=1, strobes low at T4.
5. pc=16'hFFFF, fetch, then pc_load=1 with pc_load_val=16'h0038 colliding with a fetch T4 -> pc wraps to 16'h0000 on the first fetch; pc_load wins over the increment (pc=16'h0038).
6. Assert rst during T3 of a write -> mem_wr falls without waiting for clk, pc=RESET_PC, state IDLE; the next fetch proceeds normally.
